tim_apb_master: RTL and testbench

APB4 requester that sits directly upstream of the timer's APB slave port and drives its `tim_p*` bus. It accepts single register commands from a simple valid/ready command channel, sequences the APB SETUP and ACCESS phases, and returns read data and error status on a valid/ready response channel. A configurable PREADY watchdog guarantees that every accepted command produces exactly one response.

---
 rtl/tim_apb_master_if.sv | 52 +++++
 rtl/tim_apb_master.sv | 103 ++++++++++
 tb/tb_tim_apb_master.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/tim_apb_master_if.sv
// Bus bundle for tim_apb_master: command channel, response channel and the
// APB4 requester signals that drive the timer's slave port.
interface tim_apb_master_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) ();
    // Command channel
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [DATA_W-1:0]     cmd_wdata;
    logic [DATA_W/8-1:0]   cmd_strb;

    // Response channel
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    // APB requester
    logic                  tim_psel;
    logic                  tim_penable;
    logic                  tim_pwrite;
    logic [ADDR_W-1:0]     tim_paddr;
    logic [DATA_W-1:0]     tim_pwdata;
    logic [DATA_W/8-1:0]   tim_pstrb;
    logic                  tim_pready;
    logic                  tim_pslverr;
    logic [DATA_W-1:0]     tim_prdata;

    // The requester block itself
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
        input  tim_pready, tim_pslverr, tim_prdata
    );

    // The surrounding environment: command source, response sink, APB slave
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
        output tim_pready, tim_pslverr, tim_prdata
    );
endinterface

// File: rtl/tim_apb_master.sv
// APB4 requester for the timer block. Takes one register command at a time,
// runs the SETUP/ACCESS phases, and returns read data plus error/timeout
// status. A PREADY watchdog guarantees one response per accepted command.
module tim_apb_master #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    tim_apb_master_if.master  bus
);
    localparam int          STRB_W      = DATA_W / 8;
    localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);
    localparam bit          TIMEOUT_EN  = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t     state;
    logic [7:0] wait_cnt;
    logic [7:0] wait_next;
    logic       wait_expired;

    // Watchdog: the cycle that would bring the count to TIMEOUT aborts,
    // unless PREADY is high in that same cycle (completion wins).
    assign wait_next    = wait_cnt + 8'd1;
    assign wait_expired = TIMEOUT_EN && (wait_next == TIMEOUT_CNT);

    // Transfer sequencer; every bus-facing output is a register of this FSM.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state           <= IDLE;
            wait_cnt        <= 8'd0;
            bus.cmd_ready   <= 1'b1;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_rdata   <= {DATA_W{1'b0}};
            bus.rsp_err     <= 1'b0;
            bus.rsp_timeout <= 1'b0;
            bus.tim_psel    <= 1'b0;
            bus.tim_penable <= 1'b0;
            bus.tim_pwrite  <= 1'b0;
            bus.tim_paddr   <= {ADDR_W{1'b0}};
            bus.tim_pwdata  <= {DATA_W{1'b0}};
            bus.tim_pstrb   <= {STRB_W{1'b0}};
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        // Address/data/strobes stay put until the next accept.
                        bus.cmd_ready   <= 1'b0;
                        bus.tim_pwrite  <= bus.cmd_write;
                        bus.tim_paddr   <= bus.cmd_addr;
                        bus.tim_pwdata  <= bus.cmd_wdata;
                        bus.tim_pstrb   <= bus.cmd_write ? bus.cmd_strb : {STRB_W{1'b0}};
                        bus.tim_psel    <= 1'b1;
                        bus.tim_penable <= 1'b0;
                        wait_cnt        <= 8'd0;
                        state           <= SETUP;
                    end
                end
                SETUP: begin
                    bus.tim_penable <= 1'b1;
                    state           <= ACCESS;
                end
                ACCESS: begin
                    if (bus.tim_pready) begin
                        bus.rsp_rdata   <= bus.tim_pwrite ? {DATA_W{1'b0}} : bus.tim_prdata;
                        bus.rsp_err     <= bus.tim_pslverr;
                        bus.rsp_timeout <= 1'b0;
                        bus.rsp_valid   <= 1'b1;
                        bus.tim_psel    <= 1'b0;
                        bus.tim_penable <= 1'b0;
                        state           <= RESP;
                    end else if (wait_expired) begin
                        bus.rsp_rdata   <= {DATA_W{1'b0}};
                        bus.rsp_err     <= 1'b1;
                        bus.rsp_timeout <= 1'b1;
                        bus.rsp_valid   <= 1'b1;
                        bus.tim_psel    <= 1'b0;
                        bus.tim_penable <= 1'b0;
                        state           <= RESP;
                    end else begin
                        wait_cnt <= wait_next;
                    end
                end
                RESP: begin
                    // Response fields are left untouched while stalled.
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tim_apb_master.sv
// Testbench for tim_apb_master: directed scenarios plus randomized commands
// against a transaction-level reference model and a behavioural APB slave.
module tb_tim_apb_master;
    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    tim_apb_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    tim_apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    // Slave behaviour, set per transaction by the main process
    int          slv_waits   = 0;
    logic        slv_err     = 1'b0;
    logic [31:0] slv_data    = '0;
    logic        force_ready = 1'b0;
    // Observations gathered by the slave process
    int          acc_k       = 0;
    int          setup_cnt   = 0;
    int          access_cnt  = 0;
    bit          stab_ok     = 1'b1;
    // Values the APB bus must carry while selected
    logic        exp_write   = 1'b0;
    logic [11:0] exp_addr    = '0;
    logic [31:0] exp_wdata   = '0;
    logic [3:0]  exp_strb    = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // APB slave: inserts slv_waits wait states, drives junk on PRDATA/PSLVERR
    // whenever PREADY is low, and records phase counts and bus stability.
    always @(negedge sys_clk) begin
        if (bus.tim_psel === 1'b1) begin
            if (bus.tim_paddr !== exp_addr || bus.tim_pwrite !== exp_write ||
                bus.tim_pwdata !== exp_wdata || bus.tim_pstrb !== exp_strb)
                stab_ok = 1'b0;
            if (bus.tim_penable === 1'b1) access_cnt++;
            else                          setup_cnt++;
        end
        if (bus.tim_psel === 1'b1 && bus.tim_penable === 1'b1) begin
            bus.tim_pready = force_ready || (acc_k == slv_waits);
            acc_k++;
        end else begin
            bus.tim_pready = force_ready;
            acc_k = 0;
        end
        if (bus.tim_pready) begin
            bus.tim_prdata  = slv_data;
            bus.tim_pslverr = slv_err;
        end else begin
            bus.tim_prdata  = $urandom;
            bus.tim_pslverr = 1'($urandom_range(0, 1));
        end
    end

    // One complete command, checked against the expected response and timing.
    task automatic run_cmd(input bit wr, input logic [11:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int waits, input bit serr,
                           input logic [31:0] sdata, input int stall, input bit late_pulse);
        bit          tmo;
        int          access_len;
        logic [31:0] e_rdata;
        logic        e_err;
        int          c0;
        int          n;
        bit          stall_ok;

        tmo        = (TIMEOUT != 0) && (waits >= TIMEOUT);
        access_len = tmo ? TIMEOUT : waits + 1;
        e_rdata    = (tmo || wr) ? 32'h0 : sdata;
        e_err      = tmo ? 1'b1 : serr;

        slv_waits = waits; slv_err = serr; slv_data = sdata;
        setup_cnt = 0; access_cnt = 0; stab_ok = 1'b1;
        exp_write = wr; exp_addr = addr; exp_wdata = wdata; exp_strb = wr ? strb : 4'h0;

        check("cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr;
        bus.cmd_wdata = wdata; bus.cmd_strb = strb;
        bus.rsp_ready = (stall == 0);
        c0 = cyc;
        @(negedge sys_clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_wdata = $urandom; bus.cmd_addr = 12'($urandom); bus.cmd_strb = 4'($urandom);

        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 400) begin
            @(negedge sys_clk);
            n++;
        end
        check("rsp_seen", bus.rsp_valid, 1);
        check("rsp_latency", cyc - c0, 2 + access_len);
        check("setup_cycles", setup_cnt, 1);
        check("access_cycles", access_cnt, access_len);
        check("apb_stable", stab_ok, 1);
        check("rsp_rdata", bus.rsp_rdata, e_rdata);
        check("rsp_err", bus.rsp_err, e_err);
        check("rsp_timeout", bus.rsp_timeout, tmo);

        if (stall > 0) begin
            stall_ok = 1'b1;
            bus.cmd_valid = 1'b1;
            for (int i = 0; i < stall; i++) begin
                if (late_pulse && i == 1) force_ready = 1'b1;
                if (i == 3)               force_ready = 1'b0;
                @(negedge sys_clk);
                if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e_rdata ||
                    bus.rsp_err !== e_err || bus.rsp_timeout !== tmo ||
                    bus.cmd_ready !== 1'b0 || bus.tim_psel !== 1'b0 ||
                    bus.tim_penable !== 1'b0)
                    stall_ok = 1'b0;
            end
            force_ready   = 1'b0;
            bus.cmd_valid = 1'b0;
            check("stall_stable", stall_ok, 1);
            check("stall_setup_cycles", setup_cnt, 1);
            bus.rsp_ready = 1'b1;
        end
        @(negedge sys_clk);
        check("back_to_idle", {bus.cmd_ready, bus.rsp_valid}, 2'b10);
        check("cmd_ready_cycle", cyc - c0, 2 + access_len + stall + 1);
    endtask

    // Reset in the middle of ACCESS: APB select drops at once, no response follows.
    task automatic reset_mid_transfer();
        int  n;
        bit  quiet;
        slv_waits = 1000;
        exp_write = 1'b0; exp_addr = 12'h020; exp_wdata = 32'h0; exp_strb = 4'h0;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 12'h020;
        bus.cmd_wdata = 32'h0; bus.cmd_strb = 4'hF; bus.rsp_ready = 1'b1;
        @(negedge sys_clk);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (bus.tim_penable !== 1'b1 && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        check("rst_reached_access", {bus.tim_psel, bus.tim_penable}, 2'b11);
        #2 sys_rst = 1'b1;
        #1;
        check("rst_async_psel", {bus.tim_psel, bus.tim_penable}, 2'b00);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("rst_after_release", {bus.cmd_ready, bus.rsp_valid}, 2'b10);
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (bus.rsp_valid !== 1'b0 || bus.tim_psel !== 1'b0) quiet = 1'b0;
        end
        check("rst_no_response", quiet, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
        bus.cmd_wdata = '0; bus.cmd_strb = '0; bus.rsp_ready = 1'b1;
        bus.tim_pready = 1'b0; bus.tim_pslverr = 1'b0; bus.tim_prdata = '0;

        repeat (3) @(negedge sys_clk);
        check("reset_ctrl",
              {bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout,
               bus.tim_psel, bus.tim_penable, bus.tim_pwrite}, 7'b1000000);
        check("reset_data", {bus.rsp_rdata, bus.tim_pwdata}, 64'h0);
        check("reset_addr_strb", {bus.tim_paddr, bus.tim_pstrb}, 16'h0);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // Zero-wait write
        run_cmd(1'b1, 12'h004, 32'h1234_5678, 4'hF, 0, 1'b0, 32'hA5A5_A5A5, 0, 1'b0);
        // Read with three wait states
        run_cmd(1'b0, 12'h010, 32'h0, 4'hF, 3, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);
        // Slave error on unmapped address
        run_cmd(1'b1, 12'hFFC, 32'hCAFE_0001, 4'h3, 0, 1'b1, 32'h0, 0, 1'b0);
        // Watchdog abort, late PREADY pulse during the held response
        run_cmd(1'b0, 12'h008, 32'h0, 4'h0, 1000, 1'b0, 32'h1111_2222, 6, 1'b1);
        // PREADY in the very cycle the watchdog would fire
        run_cmd(1'b0, 12'h00C, 32'h0, 4'hF, TIMEOUT - 1, 1'b0, 32'h7777_8888, 0, 1'b0);
        // Backpressure with a command waiting
        run_cmd(1'b1, 12'h014, 32'h0BAD_F00D, 4'hC, 1, 1'b0, 32'h0, 10, 1'b0);

        reset_mid_transfer();

        for (int k = 0; k < 40; k++) begin
            int          r;
            int          w;
            r = $urandom_range(0, 9);
            w = (r < 8) ? $urandom_range(0, 3) : $urandom_range(TIMEOUT - 2, TIMEOUT + 2);
            run_cmd(1'($urandom_range(0, 1)), 12'($urandom), $urandom, 4'($urandom), w,
                    1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3),
                    1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
